// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_isa_pkg
// Description : Shared ISA definitions for the 8-bit pipelined core:
//               icode constants, instruction length helper and the decode
//               pipeline register layout with its bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_isa_pkg;

  // icode values (upper nibble of the first instruction byte)
  localparam logic [3:0] c_icode_nop   = 4'h0;
  localparam logic [3:0] c_icode_irmov = 4'h1;
  localparam logic [3:0] c_icode_store = 4'h2;
  localparam logic [3:0] c_icode_load  = 4'h3;
  localparam logic [3:0] c_icode_alu   = 4'h4;
  localparam logic [3:0] c_icode_jmp   = 4'h5;
  localparam logic [3:0] c_icode_halt  = 4'h6;

  // Decode pipeline register contents
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] src_a;
    logic [3:0] dst;
    logic [7:0] val_c;
    logic [7:0] incre_pc;
    logic       write_reg;
    logic       write_alu_mem;
    logic       valid;
    logic       illegal;
  } decode_t;

  // A bubble is an all-zero register: not valid, writes nothing, not illegal
  localparam decode_t c_decode_bubble = '0;

  // Instruction length in bytes; 0 marks an undefined icode
  function automatic logic [1:0] instr_len(input logic [3:0] icode);
    case (icode)
      c_icode_nop:   instr_len = 2'd1;
      c_icode_irmov: instr_len = 2'd3;
      c_icode_store: instr_len = 2'd3;
      c_icode_load:  instr_len = 2'd3;
      c_icode_alu:   instr_len = 2'd2;
      c_icode_jmp:   instr_len = 2'd2;
      c_icode_halt:  instr_len = 2'd1;
      default:       instr_len = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_if
// Description : Bundle of the fetch/decode stage's control inputs, the
//               instruction memory port and the decode register outputs.
//               master = fetch_decode, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_decode_if;

  // Control from hazard logic and the memory stage
  logic        stall;
  logic        jmpFlag_m;
  logic [7:0]  increPC_m;

  // Instruction memory port
  logic [7:0]  addrI;
  logic [23:0] instr;

  // Decode pipeline register
  logic [3:0]  insCode_d;
  logic [3:0]  ifun_d;
  logic [3:0]  srcA_d;
  logic [3:0]  dst_d;
  logic [7:0]  valC_d;
  logic [7:0]  increPC_d;
  logic        writeReg_d;
  logic        writeAluMem_d;
  logic        valid_d;
  logic        illegal_d;
  logic        halted;

  modport master (
    input  stall, jmpFlag_m, increPC_m, instr,
    output addrI, insCode_d, ifun_d, srcA_d, dst_d, valC_d, increPC_d,
           writeReg_d, writeAluMem_d, valid_d, illegal_d, halted
  );

  modport slave (
    output stall, jmpFlag_m, increPC_m, instr,
    input  addrI, insCode_d, ifun_d, srcA_d, dst_d, valC_d, increPC_d,
           writeReg_d, writeAluMem_d, valid_d, illegal_d, halted
  );

endinterface
`default_nettype wire

// File: rtl/fetch_decode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational splitter of the 24-bit fetch window into
//               decode fields, fall-through PC and writeback controls.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import cpu_isa_pkg::*;
(
  input  logic [23:0] i_instr,
  input  logic [7:0]  i_pc,
  output decode_t     o_dec,
  output logic        o_is_halt
);

  logic [3:0] w_icode;
  logic [3:0] w_ifun;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [7:0] w_byte1;
  logic [7:0] w_byte2;
  logic [1:0] w_len;
  logic [1:0] w_step;

  assign w_icode = i_instr[23:20];
  assign w_ifun  = i_instr[19:16];
  assign w_byte1 = i_instr[15:8];
  assign w_ra    = i_instr[15:12];
  assign w_rb    = i_instr[11:8];
  assign w_byte2 = i_instr[7:0];

  // Undefined icodes still consume one byte
  assign w_len  = instr_len(w_icode);
  assign w_step = (w_len == 2'd0) ? 2'd1 : w_len;

  // Field extraction; bytes past the instruction length are left at zero
  always_comb begin
    o_dec          = c_decode_bubble;
    o_is_halt      = 1'b0;
    o_dec.icode    = w_icode;
    o_dec.ifun     = w_ifun;
    o_dec.valid    = 1'b1;
    o_dec.incre_pc = i_pc + {6'd0, w_step};
    case (w_icode)
      c_icode_nop: begin
      end
      c_icode_irmov: begin
        o_dec.src_a         = w_ra;
        o_dec.dst           = w_rb;
        o_dec.val_c         = w_byte2;
        o_dec.write_reg     = 1'b1;
        o_dec.write_alu_mem = 1'b1;
      end
      c_icode_store: begin
        o_dec.src_a = w_ra;
        o_dec.dst   = w_rb;
        o_dec.val_c = w_byte2;
      end
      c_icode_load: begin
        o_dec.src_a     = w_ra;
        o_dec.dst       = w_rb;
        o_dec.val_c     = w_byte2;
        o_dec.write_reg = 1'b1;
      end
      c_icode_alu: begin
        o_dec.src_a         = w_ra;
        o_dec.dst           = w_rb;
        o_dec.write_reg     = 1'b1;
        o_dec.write_alu_mem = 1'b1;
      end
      c_icode_jmp: begin
        // Second byte is the jump target, not a register pair
        o_dec.val_c = w_byte1;
      end
      c_icode_halt: begin
        o_is_halt = 1'b1;
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : Front end of the 8-bit core. Owns the PC, drives the
//               instruction address, decodes the fetch window into the
//               decode pipeline register and handles redirect/stall/halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode
  import cpu_isa_pkg::*;
#(
  parameter logic [7:0] RESET_PC        = 8'h00,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_decode_if.master  bus
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;
  decode_t    dec_q;
  decode_t    dec_d;
  logic       halted_q;
  logic       halted_d;

  decode_t    w_dec;
  logic       w_is_halt;
  logic       w_halt_now;

  instr_decoder u_decoder (
    .i_instr   (bus.instr),
    .i_pc      (pc_q),
    .o_dec     (w_dec),
    .o_is_halt (w_is_halt)
  );

  assign w_halt_now = w_is_halt | (HALT_ON_ILLEGAL & w_dec.illegal);

  // Next-state priority: halted freeze > redirect > stall > normal fetch
  always_comb begin
    pc_d     = pc_q;
    dec_d    = dec_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (bus.jmpFlag_m) begin
        // Redirect beats stall; whatever was being fetched is squashed
        pc_d  = bus.increPC_m;
        dec_d = c_decode_bubble;
      end else if (!bus.stall) begin
        dec_d = w_dec;
        if (w_halt_now) begin
          // PC parks on the halting instruction
          halted_d = 1'b1;
        end else begin
          pc_d = w_dec.incre_pc;
        end
      end
    end
  end

  // PC, decode register and halt flag; reset discards the decode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      dec_q    <= c_decode_bubble;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      dec_q    <= dec_d;
      halted_q <= halted_d;
    end
  end

  assign bus.addrI         = pc_q;
  assign bus.insCode_d     = dec_q.icode;
  assign bus.ifun_d        = dec_q.ifun;
  assign bus.srcA_d        = dec_q.src_a;
  assign bus.dst_d         = dec_q.dst;
  assign bus.valC_d        = dec_q.val_c;
  assign bus.increPC_d     = dec_q.incre_pc;
  assign bus.writeReg_d    = dec_q.write_reg;
  assign bus.writeAluMem_d = dec_q.write_alu_mem;
  assign bus.valid_d       = dec_q.valid;
  assign bus.illegal_d     = dec_q.illegal;
  assign bus.halted        = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Scoreboard bench for fetch_decode. A behavioural model of
//               the front end predicts the visible state after each clock;
//               a negedge monitor compares it against the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_if bus ();

  fetch_decode #(
    .RESET_PC        (8'h00),
    .HALT_ON_ILLEGAL (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Unified memory seen through the fetch window, addresses wrap at 256
  logic [7:0] mem [256];
  assign bus.instr = {mem[bus.addrI], mem[bus.addrI + 8'd1], mem[bus.addrI + 8'd2]};

  typedef struct {
    int         due;
    logic [7:0] addr;
    logic       halted;
    logic [3:0] ic;
    logic [3:0] ifn;
    logic [3:0] sa;
    logic [3:0] ds;
    logic [7:0] vc;
    logic [7:0] ip;
    logic       wr;
    logic       wam;
    logic       v;
    logic       il;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;

  // Model state
  logic [7:0] m_pc;
  logic       m_halted;
  exp_t       m_out;

  int len_tab [16] = '{1, 3, 3, 3, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.due = 0; e.addr = 8'h00; e.halted = 1'b0;
    e.ic = 4'h0; e.ifn = 4'h0; e.sa = 4'h0; e.ds = 4'h0;
    e.vc = 8'h00; e.ip = 8'h00; e.wr = 1'b0; e.wam = 1'b0; e.v = 1'b0; e.il = 1'b0;
    return e;
  endfunction

  // Reference decode straight from the instruction table
  function automatic exp_t ref_decode(input logic [7:0] pc);
    exp_t       e;
    logic [7:0] b0, b1, b2, a1, a2;
    int         len;
    a1 = pc + 8'd1;
    a2 = pc + 8'd2;
    b0 = mem[pc];
    b1 = mem[a1];
    b2 = mem[a2];
    e = bubble();
    e.ic  = b0[7:4];
    e.ifn = b0[3:0];
    len   = len_tab[b0[7:4]];
    e.v   = 1'b1;
    e.il  = (b0[7:4] > 4'd6);
    e.ip  = pc + 8'(len);
    if (len >= 2 && b0[7:4] != 4'd5) begin
      e.sa = b1[7:4];
      e.ds = b1[3:0];
    end
    if (b0[7:4] == 4'd5) e.vc = b1;
    else if (len == 3)   e.vc = b2;
    e.wr  = (b0[7:4] == 4'd1) || (b0[7:4] == 4'd3) || (b0[7:4] == 4'd4);
    e.wam = (b0[7:4] == 4'd1) || (b0[7:4] == 4'd4);
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the prediction
  task automatic step(input logic s, input logic j, input logic [7:0] t);
    exp_t e;
    bus.stall     = s;
    bus.jmpFlag_m = j;
    bus.increPC_m = t;
    if (!m_halted) begin
      if (j) begin
        m_pc  = t;
        m_out = bubble();
      end else if (!s) begin
        m_out = ref_decode(m_pc);
        if (m_out.ic == 4'd6 || m_out.il) m_halted = 1'b1;
        else m_pc = m_out.ip;
      end
    end
    e        = m_out;
    e.addr   = m_pc;
    e.halted = m_halted;
    e.due    = edge_cnt + 1;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.jmpFlag_m = 1'b0;
    bus.increPC_m = 8'h00;
    #1;
    chk("rst_addrI",   32'(bus.addrI),     32'h00);
    chk("rst_valid",   32'(bus.valid_d),   32'h0);
    chk("rst_icode",   32'(bus.insCode_d), 32'h0);
    chk("rst_halted",  32'(bus.halted),    32'h0);
    chk("rst_incrPC",  32'(bus.increPC_d), 32'h00);
    m_pc = 8'h00;
    m_halted = 1'b0;
    m_out = bubble();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compare the prediction due for the edge just taken
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
        mon_e = q.pop_front();
        if (mon_e.due == edge_cnt) begin
          chk("addrI",        32'(bus.addrI),         32'(mon_e.addr));
          chk("halted",       32'(bus.halted),        32'(mon_e.halted));
          chk("insCode_d",    32'(bus.insCode_d),     32'(mon_e.ic));
          chk("ifun_d",       32'(bus.ifun_d),        32'(mon_e.ifn));
          chk("srcA_d",       32'(bus.srcA_d),        32'(mon_e.sa));
          chk("dst_d",        32'(bus.dst_d),         32'(mon_e.ds));
          chk("valC_d",       32'(bus.valC_d),        32'(mon_e.vc));
          chk("increPC_d",    32'(bus.increPC_d),     32'(mon_e.ip));
          chk("writeReg_d",   32'(bus.writeReg_d),    32'(mon_e.wr));
          chk("writeAluMem_d",32'(bus.writeAluMem_d), 32'(mon_e.wam));
          chk("valid_d",      32'(bus.valid_d),       32'(mon_e.v));
          chk("illegal_d",    32'(bus.illegal_d),     32'(mon_e.il));
        end
      end
    end
  end

  initial begin
    bus.stall = 1'b0;
    bus.jmpFlag_m = 1'b0;
    bus.increPC_m = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // Directed program
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h00; mem[8'h02] = 8'h02;
    mem[8'h03] = 8'h41; mem[8'h04] = 8'h23;
    mem[8'h05] = 8'h21; mem[8'h06] = 8'h30; mem[8'h07] = 8'h40;
    mem[8'h08] = 8'h40; mem[8'h09] = 8'h12;
    mem[8'h0A] = 8'h60;
    mem[8'h7F] = 8'h41; mem[8'h80] = 8'h56;
    #2;
    do_reset();

    step(1'b0, 1'b0, 8'h00);
    chk("irmov_icode", 32'(bus.insCode_d), 32'h1);
    chk("irmov_dst",   32'(bus.dst_d),     32'h0);
    chk("irmov_valC",  32'(bus.valC_d),    32'h02);
    chk("irmov_incr",  32'(bus.increPC_d), 32'h03);
    chk("irmov_wr",    32'(bus.writeReg_d),32'h1);
    chk("irmov_wam",   32'(bus.writeAluMem_d), 32'h1);
    chk("irmov_addrI", 32'(bus.addrI),     32'h03);
    step(1'b0, 1'b0, 8'h00);
    chk("alu_incr",    32'(bus.increPC_d), 32'h05);
    step(1'b0, 1'b0, 8'h00);
    chk("store_incr",  32'(bus.increPC_d), 32'h08);
    chk("store_wr",    32'(bus.writeReg_d),32'h0);
    chk("store_valC",  32'(bus.valC_d),    32'h40);
    // Redirect while the ALU at 08 is fetching
    step(1'b0, 1'b1, 8'h7F);
    chk("redir_bubble", 32'(bus.valid_d),  32'h0);
    chk("redir_addrI",  32'(bus.addrI),    32'h7F);
    step(1'b0, 1'b0, 8'h00);
    chk("target_icode", 32'(bus.insCode_d), 32'h4);
    chk("target_valid", 32'(bus.valid_d),   32'h1);
    // Stall for three cycles, redirect in the second
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h0A);
    chk("stall_redir_bubble", 32'(bus.valid_d), 32'h0);
    chk("stall_redir_addrI",  32'(bus.addrI),   32'h0A);
    step(1'b1, 1'b0, 8'h00);
    // HALT at 0A
    step(1'b0, 1'b0, 8'h00);
    chk("halt_valid",  32'(bus.valid_d),   32'h1);
    chk("halt_icode",  32'(bus.insCode_d), 32'h6);
    chk("halt_flag",   32'(bus.halted),    32'h1);
    step(1'b0, 1'b1, 8'h33);
    chk("halt_addrI",  32'(bus.addrI),     32'h0A);
    step(1'b0, 1'b0, 8'h00);

    // Illegal byte halts
    do_reset();
    mem[8'h00] = 8'hF0;
    step(1'b0, 1'b0, 8'h00);
    chk("ill_flag",   32'(bus.illegal_d), 32'h1);
    chk("ill_halted", 32'(bus.halted),    32'h0 + 32'h1);
    chk("ill_addrI",  32'(bus.addrI),     32'h00);
    step(1'b0, 1'b0, 8'h00);

    // PC wrap, then asynchronous reset mid-cycle
    do_reset();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h05; mem[8'h00] = 8'h9A;
    step(1'b0, 1'b1, 8'hFE);
    step(1'b0, 1'b0, 8'h00);
    chk("wrap_valC", 32'(bus.valC_d),    32'h9A);
    chk("wrap_incr", 32'(bus.increPC_d), 32'h01);
    #2;
    do_reset();

    // Randomised phase with a mostly-legal instruction mix
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 19) == 0) mem[i] = 8'($urandom);
      else mem[i] = {4'($urandom_range(0, 6)), 4'($urandom)};
    end
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
        step(1'b0, 1'b1, 8'($urandom));
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
      end
    end
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
